bus_interface: RTL and testbench

//  Host-bus front end; sits directly upstream of the blitter register file.

---
 rtl/bus_interface_pkg.sv | 28 ++
 rtl/bus_interface_sync_ff.sv | 24 ++
 rtl/bus_interface.sv | 127 ++++++++++++
 tb/tb_bus_interface.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bus_interface_pkg.sv
// Shared types and widths for the host-bus front end.
package bus_interface_pkg;

    localparam int unsigned BUS_SYNC_DEFAULT = 2;
    localparam int unsigned REG_NUM_W        = 4;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned WORD_W           = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACTIVE = 2'd2
    } bus_state_t;

    // Host request as registered from the pins
    typedef struct packed {
        logic                 rd_nwr;
        logic [REG_NUM_W-1:0] reg_num;
        logic                 bytesel;
        logic [BYTE_W-1:0]    data;
    } bus_req_t;

    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] even_byte,
                                                    input logic [BYTE_W-1:0] odd_byte);
        return {even_byte, odd_byte};
    endfunction

endpackage

// File: rtl/bus_interface_sync_ff.sv
// Generic single-bit multi-flop synchroniser with synchronous reset value.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_interface.sv
// Host-bus front end: synchronises cs_n, detects accesses, emits one-cycle
// read/write strobes and assembles 16-bit words from even/odd byte writes.
module bus_interface
    import bus_interface_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = BUS_SYNC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 bus_cs_n_i,
    input  logic                 bus_rd_nwr_i,
    input  logic [REG_NUM_W-1:0] bus_reg_num_i,
    input  logic                 bus_bytesel_i,
    input  logic [BYTE_W-1:0]    bus_data_i,
    output logic                 wr_strobe_o,
    output logic                 rd_strobe_o,
    output logic                 word_wr_o,
    output logic [REG_NUM_W-1:0] reg_num_o,
    output logic                 bytesel_o,
    output logic [BYTE_W-1:0]    byte_data_o,
    output logic [WORD_W-1:0]    word_data_o,
    output logic                 bus_ack_o
);

    bus_req_t          req_q;
    logic              cs_sync;
    logic              cs_prev;
    logic              fall_c;
    logic              accept_c;
    logic              rd_hold;
    logic [BYTE_W-1:0] even_latch;
    bus_state_t        state;
    bus_state_t        state_next;

    // Control/data are stable for the whole access, so one plain stage suffices
    always_ff @(posedge clk) begin
        req_q <= {bus_rd_nwr_i, bus_reg_num_i, bus_bytesel_i, bus_data_i};
    end

    // Chain resets to "asserted" so an access live across reset is never seen as new
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_cs_sync (
        .clk     (clk),
        .reset_i (reset_i),
        .d       (bus_cs_n_i),
        .q       (cs_sync)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cs_prev <= 1'b0;
        end else begin
            cs_prev <= cs_sync;
        end
    end

    assign fall_c = cs_prev & ~cs_sync;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (fall_c) begin
                    state_next = STROBE;
                    accept_c   = 1'b1;
                end
            end
            STROBE: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                if (cs_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Hold regs load on acceptance; strobes follow one cycle later from STROBE
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_strobe_o <= 1'b0;
            rd_strobe_o <= 1'b0;
            word_wr_o   <= 1'b0;
            bus_ack_o   <= 1'b0;
            reg_num_o   <= '0;
            bytesel_o   <= 1'b0;
            byte_data_o <= '0;
            word_data_o <= '0;
            even_latch  <= '0;
            rd_hold     <= 1'b0;
        end else begin
            wr_strobe_o <= (state == STROBE) & ~rd_hold;
            rd_strobe_o <= (state == STROBE) &  rd_hold;
            word_wr_o   <= (state == STROBE) & ~rd_hold & bytesel_o;
            bus_ack_o   <= (state != IDLE);
            if (accept_c) begin
                reg_num_o <= req_q.reg_num;
                bytesel_o <= req_q.bytesel;
                rd_hold   <= req_q.rd_nwr;
                if (!req_q.rd_nwr) begin
                    byte_data_o <= req_q.data;
                    if (req_q.bytesel) begin
                        word_data_o <= pack_word(even_latch, req_q.data);
                    end else begin
                        even_latch <= req_q.data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_interface.sv
// Directed self-checking bench for bus_interface.
module tb_bus_interface;

    localparam int unsigned SYNC = 2;
    // cs_n driven just after edge k0 is sampled at k0+1; strobe follows SYNC+1 edges later
    localparam int STROBE_AT = int'(SYNC) + 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic [3:0]  bus_reg_num_i;
    logic        bus_bytesel_i;
    logic [7:0]  bus_data_i;
    logic        wr_strobe_o;
    logic        rd_strobe_o;
    logic        word_wr_o;
    logic [3:0]  reg_num_o;
    logic        bytesel_o;
    logic [7:0]  byte_data_o;
    logic [15:0] word_data_o;
    logic        bus_ack_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_n, rd_n, word_n, wr_at, rd_at, word_at;

    always #5 clk = ~clk;

    bus_interface #(.SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .bus_cs_n_i    (bus_cs_n_i),
        .bus_rd_nwr_i  (bus_rd_nwr_i),
        .bus_reg_num_i (bus_reg_num_i),
        .bus_bytesel_i (bus_bytesel_i),
        .bus_data_i    (bus_data_i),
        .wr_strobe_o   (wr_strobe_o),
        .rd_strobe_o   (rd_strobe_o),
        .word_wr_o     (word_wr_o),
        .reg_num_o     (reg_num_o),
        .bytesel_o     (bytesel_o),
        .byte_data_o   (byte_data_o),
        .word_data_o   (word_data_o),
        .bus_ack_o     (bus_ack_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        wr_n = 0; rd_n = 0; word_n = 0;
        wr_at = -1; rd_at = -1; word_at = -1;
    endtask

    // Sample strobes on the falling edge; idx counts edges since the drive edge
    task automatic watch(input int cycles, input int base);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wr_strobe_o) begin wr_n++;   if (wr_at < 0)   wr_at = base + i;   end
            if (rd_strobe_o) begin rd_n++;   if (rd_at < 0)   rd_at = base + i;   end
            if (word_wr_o)   begin word_n++; if (word_at < 0) word_at = base + i; end
        end
    endtask

    task automatic do_access(input logic rd, input logic [3:0] rn, input logic bs,
                             input logic [7:0] d, input int low, input int high);
        clear_counts();
        @(posedge clk); #1;
        bus_rd_nwr_i  = rd;
        bus_reg_num_i = rn;
        bus_bytesel_i = bs;
        bus_data_i    = d;
        bus_cs_n_i    = 1'b0;
        watch(low, 0);
        @(posedge clk); #1;
        bus_cs_n_i = 1'b1;
        watch(high, low);
    endtask

    initial begin
        reset_i       = 1'b1;
        bus_cs_n_i    = 1'b1;
        bus_rd_nwr_i  = 1'b0;
        bus_reg_num_i = 4'd0;
        bus_bytesel_i = 1'b0;
        bus_data_i    = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        // 1: idle after reset
        clear_counts();
        watch(20, 0);
        check("idle_strobes", 32'(wr_n + rd_n + word_n), 32'd0);
        check("idle_ack",     32'(bus_ack_o),   32'd0);
        check("idle_reg",     32'(reg_num_o),   32'd0);
        check("idle_byte",    32'(byte_data_o), 32'd0);
        check("idle_word",    32'(word_data_o), 32'd0);

        // 2: even-byte write
        do_access(1'b0, 4'd3, 1'b0, 8'hA5, 8, 8);
        check("w0_wr_n",   32'(wr_n),        32'd1);
        check("w0_wr_at",  32'(wr_at),       32'(STROBE_AT));
        check("w0_word_n", 32'(word_n),      32'd0);
        check("w0_rd_n",   32'(rd_n),        32'd0);
        check("w0_reg",    32'(reg_num_o),   32'd3);
        check("w0_byte",   32'(byte_data_o), 32'hA5);
        check("w0_bsel",   32'(bytesel_o),   32'd0);
        check("w0_ack",    32'(bus_ack_o),   32'd0);

        // 3: odd-byte write assembles word
        do_access(1'b0, 4'd3, 1'b1, 8'h5A, 8, 8);
        check("w1_wr_n",    32'(wr_n),        32'd1);
        check("w1_word_n",  32'(word_n),      32'd1);
        check("w1_same",    32'(word_at),     32'(wr_at));
        check("w1_word",    32'(word_data_o), 32'hA55A);
        check("w1_byte",    32'(byte_data_o), 32'h5A);

        // Repeated odd write reuses the even latch
        do_access(1'b0, 4'd7, 1'b1, 8'hC3, 8, 8);
        check("w2_word", 32'(word_data_o), 32'hA5C3);

        // Even reg number does not matter for pairing
        do_access(1'b0, 4'd2, 1'b0, 8'h11, 8, 8);
        do_access(1'b0, 4'd5, 1'b1, 8'h22, 8, 8);
        check("w3_word", 32'(word_data_o), 32'h1122);
        check("w3_reg",  32'(reg_num_o),   32'd5);

        // 4: read leaves data outputs alone
        do_access(1'b1, 4'd9, 1'b1, 8'hFF, 8, 8);
        check("rd_rd_n",  32'(rd_n),        32'd1);
        check("rd_at",    32'(rd_at),       32'(STROBE_AT));
        check("rd_wr_n",  32'(wr_n + word_n), 32'd0);
        check("rd_reg",   32'(reg_num_o),   32'd9);
        check("rd_bsel",  32'(bytesel_o),   32'd1);
        check("rd_byte",  32'(byte_data_o), 32'h22);
        check("rd_word",  32'(word_data_o), 32'h1122);

        // 5: cs_n low across reset
        @(posedge clk); #1;
        reset_i       = 1'b1;
        bus_rd_nwr_i  = 1'b0;
        bus_reg_num_i = 4'd4;
        bus_bytesel_i = 1'b0;
        bus_data_i    = 8'h77;
        bus_cs_n_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        clear_counts();
        watch(12, 0);
        check("rst_strobes", 32'(wr_n + rd_n + word_n), 32'd0);
        check("rst_ack",     32'(bus_ack_o),  32'd0);
        check("rst_reg",     32'(reg_num_o),  32'd0);
        @(posedge clk); #1 bus_cs_n_i = 1'b1;
        repeat (8) @(posedge clk);
        // Even latch was cleared by reset
        do_access(1'b0, 4'd6, 1'b1, 8'h44, 8, 8);
        check("post_rst_wr_n", 32'(wr_n),        32'd1);
        check("post_rst_word", 32'(word_data_o), 32'h0044);
        check("post_rst_reg",  32'(reg_num_o),   32'd6);

        // 6: long access with a one-cycle high glitch
        clear_counts();
        @(posedge clk); #1;
        bus_rd_nwr_i  = 1'b0;
        bus_reg_num_i = 4'd1;
        bus_bytesel_i = 1'b0;
        bus_data_i    = 8'h0F;
        bus_cs_n_i    = 1'b0;
        watch(20, 0);
        check("gl_ack_mid", 32'(bus_ack_o), 32'd1);
        @(posedge clk); #1 bus_cs_n_i = 1'b1;
        @(posedge clk); #1 bus_cs_n_i = 1'b0;
        watch(19, 21);
        check("gl_wr_range", 32'((wr_n >= 1) && (wr_n <= 2)), 32'd1);
        check("gl_rd_n",     32'(rd_n), 32'd0);
        @(posedge clk); #1 bus_cs_n_i = 1'b1;
        watch(int'(SYNC) + 3, 0);
        check("gl_ack_drop", 32'(bus_ack_o), 32'd0);
        check("gl_byte",     32'(byte_data_o), 32'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
